// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU issue scheduler.
// Holds the scheduler state enum, the FPU opcode width and the quiet-NaN
// value delivered when an operation times out.
package fpu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } sched_state_e;

  localparam int          FPU_OP_W = 5;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

endpackage

// File: rtl/fpu_sched.sv
// fpu_sched: single-outstanding FPU scheduler between exec stage, FPU and writeback.
// Latency: accept -> fpu_start next cycle; fpu_fin -> wb_valid next cycle (min 2 cycles accept-to-wb_valid).
// Backpressure: issue_ready drops while an op is in flight or its result waits on wb_ready; stall = issue_valid & !issue_ready.
// Ports: clk/rst (sync, active-high); issue_* (exec handshake + opcode/operands/rd);
//   fpu_start/fpu_op/fpu_src0/fpu_src1 to the FPU, fpu_fin/fpu_result back; flush (kill in-flight op);
//   stall; wb_valid/wb_ready/wb_rd/wb_result (writeback handshake); timeout_err (sticky).
// Optional feature: define FPU_TIMEOUT_EN to add the BUSY/DRAIN watchdog of TIMEOUT_CYC cycles.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [FPU_OP_W-1:0] issue_fpuop,
  input  logic [31:0]         issue_src0,
  input  logic [31:0]         issue_src1,
  input  logic [5:0]          issue_rd,
  output logic                fpu_start,
  output logic [FPU_OP_W-1:0] fpu_op,
  output logic [31:0]         fpu_src0,
  output logic [31:0]         fpu_src1,
  input  logic                fpu_fin,
  input  logic [31:0]         fpu_result,
  input  logic                flush,
  output logic                stall,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [5:0]          wb_rd,
  output logic [31:0]         wb_result,
  output logic                timeout_err
);

  sched_state_e        state;
  logic [FPU_OP_W-1:0] op_q;
  logic [31:0]         src0_q;
  logic [31:0]         src1_q;
  logic [5:0]          rd_q;
  logic [31:0]         res_q;
  logic                accept;
  logic                tmo_fire;  // watchdog actually ends the op this cycle

  // A result can be retired and a new op accepted in the same DONE cycle.
  // Gated by rst so every output reads 0 while reset is held.
  assign issue_ready = !rst && ((state == IDLE) || (state == DONE && wb_ready && !flush));
  assign stall       = !rst && issue_valid && !issue_ready;
  assign accept      = issue_valid && issue_ready && !flush;

  assign fpu_op    = op_q;
  assign fpu_src0  = src0_q;
  assign fpu_src1  = src1_q;
  assign wb_rd     = rd_q;
  assign wb_result = res_q;

`ifdef FPU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err_q;
  logic             tmo_hit;

  // Counter keeps running from BUSY into DRAIN, so a flushed op gets no fresh budget.
  assign tmo_hit  = (state == BUSY || state == DRAIN) && (tmo_cnt >= CNT_W'(TIMEOUT_CYC - 1));
  assign tmo_fire = tmo_hit && !fpu_fin && !(state == BUSY && flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == BUSY || state == DRAIN) tmo_cnt <= tmo_cnt + 1'b1;
      else                                 tmo_cnt <= '0;
      if (tmo_fire) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      fpu_start <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      wb_valid  <= 1'b0;
      if (accept) begin
        op_q   <= issue_fpuop;
        src0_q <= issue_src0;
        src1_q <= issue_src1;
        rd_q   <= issue_rd;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            fpu_start <= 1'b1;
          end
        end
        START, BUSY: begin
          // flush outranks a same-cycle fin: the op is killed, result dropped in DRAIN
          if (flush) begin
            state <= DRAIN;
          end else if (fpu_fin) begin
            res_q    <= fpu_result;
            state    <= DONE;
            wb_valid <= 1'b1;
          end else if (tmo_fire) begin
            res_q    <= QNAN;
            state    <= DONE;
            wb_valid <= 1'b1;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (wb_ready) begin
            if (accept) begin
              state     <= START;
              fpu_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            wb_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (fpu_fin || tmo_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: directed scenarios plus randomized op streams
// checked against per-op expectations (operands sent, fin delay, result, writeback stall).
module tb_fpu_sched;
  import fpu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_fpuop;
  logic [31:0] issue_src0, issue_src1;
  logic [5:0]  issue_rd;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_src0, fpu_src1;
  logic        fpu_fin;
  logic [31:0] fpu_result;
  logic        flush;
  logic        stall;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Per-op stimulus/expectation table.
  logic [4:0]  a_op  [8];
  logic [31:0] a_s0  [8];
  logic [31:0] a_s1  [8];
  logic [5:0]  a_rd  [8];
  logic [31:0] a_res [8];
  int          a_d   [8];  // cycles after START at which fin is raised
  int          a_w   [8];  // cycles wb_ready stays low once the result is out

  always #5 clk = ~clk;

  fpu_sched #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fpuop(issue_fpuop),
    .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_rd(issue_rd),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_src0(fpu_src0), .fpu_src1(fpu_src1),
    .fpu_fin(fpu_fin), .fpu_result(fpu_result), .flush(flush), .stall(stall),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_result(wb_result),
    .timeout_err(timeout_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; fpu_fin = 0; flush = 0; wb_ready = 0; fpu_result = '0;
  endtask

  // Present one op for a single accept cycle; returns positioned in START.
  task automatic accept_op(input logic [4:0] op, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [5:0] rd);
    issue_fpuop = op; issue_src0 = s0; issue_src1 = s1; issue_rd = rd; issue_valid = 1;
    #1;
    cyc();
    issue_valid = 0;
  endtask

  // Run ops 0..n-1 from the table; each accept after the first coincides with the previous writeback.
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      issue_fpuop = a_op[i]; issue_src0 = a_s0[i]; issue_src1 = a_s1[i]; issue_rd = a_rd[i];
      issue_valid = 1; wb_ready = (i > 0); fpu_fin = 0; #1;
      total++;
      if (issue_ready !== 1'b1 || stall !== 1'b0) begin
        bad++; $display("FAIL accept_ready op%0d: ready=%b stall=%b want 1/0", i, issue_ready, stall);
      end
      if (i > 0) begin
        total++;
        if (wb_valid !== 1'b1 || wb_result !== a_res[i-1] || wb_rd !== a_rd[i-1]) begin
          bad++; $display("FAIL wb_handoff op%0d: vld=%b res=%h rd=%0d want 1/%h/%0d",
                          i-1, wb_valid, wb_result, wb_rd, a_res[i-1], a_rd[i-1]);
        end
      end
      cyc();
      // START cycle
      issue_valid = 0; wb_ready = 0;
      fpu_fin = (a_d[i] == 0); fpu_result = (a_d[i] == 0) ? a_res[i] : $urandom; #1;
      total++;
      if (fpu_start !== 1'b1 || wb_valid !== 1'b0 ||
          {fpu_op, fpu_src0, fpu_src1} !== {a_op[i], a_s0[i], a_s1[i]}) begin
        bad++; $display("FAIL start op%0d: start=%b vld=%b op=%h s0=%h s1=%h want 1/0/%h/%h/%h",
                        i, fpu_start, wb_valid, fpu_op, fpu_src0, fpu_src1, a_op[i], a_s0[i], a_s1[i]);
      end
      cyc();
      for (int k = 1; k <= a_d[i]; k++) begin
        fpu_fin = (k == a_d[i]); fpu_result = (k == a_d[i]) ? a_res[i] : $urandom; #1;
        total++;
        if (fpu_start !== 1'b0 || wb_valid !== 1'b0 ||
            {fpu_op, fpu_src0, fpu_src1} !== {a_op[i], a_s0[i], a_s1[i]}) begin
          bad++; $display("FAIL busy_hold op%0d k%0d: start=%b vld=%b s0=%h want 0/0/%h",
                          i, k, fpu_start, wb_valid, fpu_src0, a_s0[i]);
        end
        cyc();
      end
      fpu_fin = 0;
      // Result held under writeback back-pressure; stray fins must be ignored.
      for (int k = 0; k < a_w[i]; k++) begin
        issue_valid = (i + 1 < n) ? 1'($urandom_range(0, 1)) : 1'b0;
        fpu_fin = 1'($urandom_range(0, 1)); fpu_result = $urandom; wb_ready = 0; #1;
        total++;
        if (wb_valid !== 1'b1 || wb_result !== a_res[i] || wb_rd !== a_rd[i] || fpu_start !== 1'b0) begin
          bad++; $display("FAIL wb_hold op%0d k%0d: vld=%b res=%h rd=%0d want 1/%h/%0d",
                          i, k, wb_valid, wb_result, wb_rd, a_res[i], a_rd[i]);
        end
        total++;
        if (issue_ready !== 1'b0 || stall !== issue_valid) begin
          bad++; $display("FAIL stall op%0d k%0d: ready=%b stall=%b want 0/%b", i, k, issue_ready, stall, issue_valid);
        end
        cyc();
      end
      issue_valid = 0; fpu_fin = 0;
    end
    wb_ready = 1; #1;
    total++;
    if (wb_valid !== 1'b1 || wb_result !== a_res[n-1] || wb_rd !== a_rd[n-1]) begin
      bad++; $display("FAIL wb_last: vld=%b res=%h rd=%0d want 1/%h/%0d",
                      wb_valid, wb_result, wb_rd, a_res[n-1], a_rd[n-1]);
    end
    cyc();
    wb_ready = 0; #1;
    total++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || fpu_start !== 1'b0) begin
      bad++; $display("FAIL retire_idle: vld=%b ready=%b start=%b want 0/1/0", wb_valid, issue_ready, fpu_start);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; issue_valid = 1;
    cyc(); cyc();
    total++;
    if (issue_ready !== 1'b0 || stall !== 1'b0 || fpu_start !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL in_reset: ready=%b stall=%b start=%b vld=%b want 0", issue_ready, stall, fpu_start, wb_valid);
    end
    rst = 0; issue_valid = 0; #1;
    total++;
    if ({fpu_start, fpu_op, fpu_src0, fpu_src1, wb_valid, wb_rd, wb_result, timeout_err, stall} !== '0 ||
        issue_ready !== 1'b1) begin
      bad++; $display("FAIL after_reset: s0=%h res=%h vld=%b ready=%b terr=%b want zeros/ready=1",
                      fpu_src0, wb_result, wb_valid, issue_ready, timeout_err);
    end
  endtask

  task automatic test_single();
    a_op[0] = 5'h01; a_s0[0] = 32'h3F800000; a_s1[0] = 32'h3F800000; a_rd[0] = 6'd3;
    a_res[0] = 32'h40000000; a_d[0] = 3; a_w[0] = 0;
    run_seq(1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        a_op[i] = 5'($urandom); a_s0[i] = $urandom; a_s1[i] = $urandom; a_rd[i] = 6'($urandom);
        a_res[i] = $urandom; a_d[i] = $urandom_range(0, 4); a_w[i] = $urandom_range(0, 3);
      end
      a_w[1] = 3;
      run_seq(6);
    end
  endtask

  task automatic test_flush_busy();
    accept_op(5'h02, 32'h11111111, 32'h22222222, 6'd7);
    cyc(); cyc();               // two BUSY cycles
    flush = 1; #1;
    total++;
    if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_busy_ready: %b want 0", issue_ready); end
    cyc();
    flush = 0;
    cyc();
    fpu_fin = 1; fpu_result = 32'hDEADBEEF; #1;
    total++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b0 || fpu_src0 !== 32'h11111111) begin
      bad++; $display("FAIL drain_hold: vld=%b ready=%b s0=%h want 0/0/11111111", wb_valid, issue_ready, fpu_src0);
    end
    cyc();
    fpu_fin = 0; #1;
    total++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL drain_exit: vld=%b ready=%b want 0/1", wb_valid, issue_ready);
    end
    a_op[0] = 5'h03; a_s0[0] = 32'h0000ABCD; a_s1[0] = 32'h12340000; a_rd[0] = 6'd9;
    a_res[0] = 32'hCAFEF00D; a_d[0] = 1; a_w[0] = 1;
    run_seq(1);
  endtask

  task automatic test_flush_fin();
    logic saw_vld;
    accept_op(5'h04, 32'h33333333, 32'h44444444, 6'd12);
    cyc();                      // BUSY
    flush = 1; fpu_fin = 1; fpu_result = 32'h55555555;
    cyc();
    flush = 0; fpu_fin = 0; saw_vld = 0;
    for (int k = 0; k < 5; k++) begin
      #1; if (wb_valid !== 1'b0 || issue_ready !== 1'b0) saw_vld = 1;
      cyc();
    end
    total++;
    if (saw_vld !== 1'b0) begin bad++; $display("FAIL flush_fin_drain: left DRAIN or wb_valid=1, want stay in DRAIN"); end
    fpu_fin = 1; cyc(); fpu_fin = 0; #1;
    total++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL flush_fin_exit: vld=%b ready=%b want 0/1", wb_valid, issue_ready);
    end
  endtask

  task automatic test_flush_done();
    accept_op(5'h05, 32'h66666666, 32'h77777777, 6'd20);
    fpu_fin = 1; fpu_result = 32'h88888888;
    cyc();
    fpu_fin = 0; #1;
    total++;
    if (wb_valid !== 1'b1 || wb_result !== 32'h88888888) begin
      bad++; $display("FAIL min_latency: vld=%b res=%h want 1/88888888", wb_valid, wb_result);
    end
    flush = 1; wb_ready = 1; issue_valid = 1; #1;
    total++;
    if (issue_ready !== 1'b0 || stall !== 1'b1) begin
      bad++; $display("FAIL flush_done_ready: ready=%b stall=%b want 0/1", issue_ready, stall);
    end
    cyc();
    flush = 0; wb_ready = 0; issue_valid = 0; #1;
    total++;
    if (wb_valid !== 1'b0 || fpu_start !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL flush_done_drop: vld=%b start=%b ready=%b want 0/0/1", wb_valid, fpu_start, issue_ready);
    end
  endtask

  task automatic test_flush_idle();
    issue_valid = 1; flush = 1; fpu_fin = 1; fpu_result = 32'h99999999; #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: %b want 0", stall); end
    cyc();
    issue_valid = 0; flush = 0; fpu_fin = 0; #1;
    total++;
    if (fpu_start !== 1'b0 || wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle_block: start=%b vld=%b ready=%b want 0/0/1", fpu_start, wb_valid, issue_ready);
    end
  endtask

  task automatic test_reset_mid();
    accept_op(5'h1F, 32'hFFFF0000, 32'h0000FFFF, 6'd63);
    cyc();                      // BUSY
    rst = 1; cyc(); rst = 0; #1;
    total++;
    if ({fpu_start, fpu_op, fpu_src0, fpu_src1, wb_valid, wb_rd, wb_result, timeout_err, stall} !== '0 ||
        issue_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid: s0=%h op=%h vld=%b ready=%b want zeros/ready=1", fpu_src0, fpu_op, wb_valid, issue_ready);
    end
    fpu_fin = 1; fpu_result = 32'h12121212;
    cyc();
    fpu_fin = 0; #1;
    total++;
    if (wb_valid !== 1'b0 || wb_result !== 32'h0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL stray_fin: vld=%b res=%h ready=%b want 0/0/1", wb_valid, wb_result, issue_ready);
    end
  endtask

`ifdef FPU_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    accept_op(5'h06, 32'h1, 32'h2, 6'd5);
    c = 0;
    while (wb_valid !== 1'b1 && c < 20) begin cyc(); c++; end
    total++;
    if (c !== 9) begin bad++; $display("FAIL timeout_cycles: START-to-DONE %0d want 9", c); end
    total++;
    if (wb_result !== QNAN || timeout_err !== 1'b1 || wb_rd !== 6'd5) begin
      bad++; $display("FAIL timeout_result: res=%h terr=%b rd=%0d want 7fc00000/1/5", wb_result, timeout_err, wb_rd);
    end
    wb_ready = 1; cyc(); wb_ready = 0;
    a_op[0] = 5'h07; a_s0[0] = 32'hA; a_s1[0] = 32'hB; a_rd[0] = 6'd1;
    a_res[0] = 32'h3; a_d[0] = 2; a_w[0] = 0;
    run_seq(1);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: %b want 1", timeout_err); end
    accept_op(5'h08, 32'hC, 32'hD, 6'd2);
    cyc();
    flush = 1; cyc(); flush = 0;
    c = 0;
    while (issue_ready !== 1'b1 && c < 20) begin
      total++;
      if (wb_valid !== 1'b0) begin bad++; $display("FAIL drain_timeout_vld: %b want 0", wb_valid); end
      cyc(); c++;
    end
    total++;
    if (c >= 20) begin bad++; $display("FAIL drain_timeout_exit: still draining after %0d cycles want IDLE", c); end
    rst = 1; cyc(); rst = 0; #1;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: %b want 0", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    logic bad_wait;
    accept_op(5'h06, 32'h1, 32'h2, 6'd5);
    bad_wait = 0;
    for (int k = 0; k < 30; k++) begin
      #1; if (wb_valid !== 1'b0 || timeout_err !== 1'b0 || issue_ready !== 1'b0) bad_wait = 1;
      cyc();
    end
    total++;
    if (bad_wait !== 1'b0) begin bad++; $display("FAIL no_timeout_wait: op ended or timeout_err set without fin"); end
    fpu_fin = 1; fpu_result = 32'h0BADCAFE; cyc(); fpu_fin = 0; #1;
    total++;
    if (wb_valid !== 1'b1 || wb_result !== 32'h0BADCAFE || timeout_err !== 1'b0) begin
      bad++; $display("FAIL late_fin: vld=%b res=%h terr=%b want 1/0badcafe/0", wb_valid, wb_result, timeout_err);
    end
    wb_ready = 1; cyc(); wb_ready = 0;
  endtask
`endif

  initial begin
    rst = 0; clear_inputs();
    issue_fpuop = '0; issue_src0 = '0; issue_src1 = '0; issue_rd = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush_busy();
    test_flush_fin();
    test_flush_done();
    test_flush_idle();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: max cycles allowed from fpu_start to fpu_fin before timeout.
REQ-002 Ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  exec stage presents an FPU instruction.
- issue_ready  out  1  scheduler accepts the instruction this cycle.
- issue_fpuop  in  5  FPU opcode.
- issue_src0, issue_src1  in  32  operands.
- issue_rd  in  6  destination register.
- fpu_start  out  1  one-cycle start pulse to the FPU.
- fpu_op  out  5  opcode held to the FPU.
- fpu_src0, fpu_src1  out  32  operands held to the FPU.
- fpu_fin  in  1  FPU completion strobe.
- fpu_result  in  32  FPU result, valid with fpu_fin.
- flush  in  1  branch/jump miss; kill in-flight op.
- stall  out  1  freeze upstream pipeline.
- wb_valid  out  1  result available for writeback.
- wb_ready  in  1  writeback consumes result.
- wb_rd  out  6  destination of delivered result.
- wb_result  out  32  delivered result.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have states IDLE, START, BUSY, DONE and DRAIN.
REQ-004 issue_ready SHALL be 1 in IDLE, and in DONE when wb_ready=1 and flush=0; 0 otherwise.
REQ-005 On accept (issue_valid & issue_ready & !flush), the block SHALL latch opcode, operands and rd, and enter START.
REQ-006 START SHALL last one cycle with fpu_start=1, then go to BUSY; fpu_start SHALL be 0 in every other state.
REQ-007 fpu_op and fpu_src0/1 SHALL hold the latched values from START until the state leaves BUSY.
REQ-008 fpu_fin in START or BUSY SHALL capture fpu_result and move to DONE on the next edge; minimum accept-to-wb_valid latency is 2 cycles.
REQ-009 In DONE, wb_valid SHALL be 1 with stable wb_rd and wb_result until wb_ready=1; the state then goes to IDLE, or to START if a new op is accepted in the same cycle.
REQ-010 stall SHALL equal issue_valid & !issue_ready.
REQ-011 fpu_fin in IDLE or DONE SHALL be ignored.
REQ-012 flush in START or BUSY SHALL go to DRAIN; flush in DONE SHALL drop the result and go to IDLE; flush in IDLE SHALL block the accept.
REQ-013 DRAIN SHALL hold the FPU inputs, discard the result on fpu_fin and go to IDLE, and never assert wb_valid.
REQ-014 flush takes priority over fpu_fin and wb_ready in the same cycle.

Reset
REQ-015 On rst=1 the block SHALL enter IDLE, clear latched data, clear the timeout counter, and drive all outputs to 0 (issue_ready becomes 1 after reset).
REQ-016 rst during START, BUSY or DRAIN SHALL abandon the op; a later fpu_fin SHALL be ignored per REQ-011.

Configuration
REQ-017 With macro FPU_TIMEOUT_EN defined, a counter SHALL run in BUSY/DRAIN; on reaching TIMEOUT_CYC, BUSY goes to DONE with wb_result=32'h7FC00000, DRAIN goes to IDLE, and timeout_err sets and stays set until rst.
REQ-018 Without FPU_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and BUSY/DRAIN wait indefinitely.

Structure
REQ-019 A shared package SHALL hold the sched_state_e enum, the FPU opcode width constant (5) and the QNAN constant 32'h7FC00000.
REQ-020 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-021 Single op: accept at cycle 0 with src0=32'h3F800000, fin at cycle 4 with result 32'h40000000 -> fpu_start at cycle 1 only, wb_valid from cycle 5 with wb_result=32'h40000000.
REQ-022 Back-pressure and back-to-back: wb_ready low for 3 cycles -> wb_valid and data stable, stall=1 for a pending issue; wb_ready=1 with issue_valid=1 -> next fpu_start on the following cycle.
REQ-023 Flush in BUSY, fin 2 cycles later -> no wb_valid, IDLE after fin, next op accepted normally.
REQ-024 Flush and fin in the same BUSY cycle -> DRAIN, result dropped, wb_valid never asserted.
REQ-025 With FPU_TIMEOUT_EN and TIMEOUT_CYC=8, no fin -> after 8 BUSY cycles wb_result=32'h7FC00000 and timeout_err=1, cleared only by rst.
REQ-026 rst mid-BUSY, then a stray fin -> all outputs 0, issue_ready=1, fin ignored.
